instr_cache: RTL and testbench
==============================

Name: instr_cache

Overview:
- Direct-mapped, read-only instruction cache between the fetch-stage PC register and a slower backing instruction memory.
- Replaces the combinational instr_mem lookup.
- On a hit it returns the instruction in the same cycle.
- On a miss it drives stall_o so the fetch stage holds, then refills the whole line over a per-word req/valid handshake.

Parameters:
- DATA_WIDTH, 32, instruction/data word width.
- ADDR_WIDTH, 32, byte address width.
- NUM_SETS, 64, number of lines; power of two, at least 2.
- LINE_WORDS, 4, words per line; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  1  fetch wants an instruction this cycle.
- pc_i  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- flush_i  in  1  invalidate all lines (fence.i / self-modifying code).
- instr_o  out  DATA_WIDTH  instruction for pc_i; valid when req_i && !stall_o.
- stall_o  out  1  fetch must hold pc_i and not advance.
- mem_req_o  out  1  beat request to backing memory.
- mem_addr_o  out  ADDR_WIDTH  word-aligned beat address.
- mem_valid_i  in  1  backing memory returns data for the current beat.
- mem_rdata_i  in  DATA_WIDTH  beat data, sampled when mem_req_o && mem_valid_i.
- miss_count_o  out  32  number of misses since reset, wrapping.

Behaviour:
- Address split:
  - OFF_W = log2(LINE_WORDS), IDX_W = log2(NUM_SETS).
  - word offset = pc[2+OFF_W-1:2].
  - index = pc[2+OFF_W+IDX_W-1:2+OFF_W].
  - tag = remaining upper bits (22 bits at defaults).
- Storage:
  - Per set: valid bit, tag, LINE_WORDS data words, all in flops so reads are combinational.
  - Only the valid bits are reset.
- Reset: state=LOOKUP, all valid=0, mem_req_o=0, mem_addr_o=0, miss_count_o=0, refill beat counter=0, kill=0.
- hit = valid[index] && tag matches.
- LOOKUP state:
  - instr_o = data[index][word offset], combinational.
  - stall_o = req_i && !hit.
  - If req_i && !hit and flush_i=0: latch line base address (pc with offset and byte bits zeroed), miss_count_o += 1, go to REFILL.
  - In the cycle after entry to REFILL: mem_req_o=1, mem_addr_o=base.
  - When req_i=0: stall_o=0, no memory activity.
- REFILL state:
  - stall_o=1.
  - mem_req_o and mem_addr_o stay stable until mem_valid_i.
  - On each accepted beat: write mem_rdata_i into data[latched index][beat]; beat increments; mem_addr_o advances by 4 the next cycle with mem_req_o still high.
  - After beat LINE_WORDS-1 is accepted: mem_req_o=0. If kill=0, set valid and tag for the latched index. Go to DONE.
  - Refill writes overwrite the old line data, but that line's valid bit is cleared on entry to REFILL.
- DONE state: stall_o=1 for exactly one cycle, then LOOKUP. The re-lookup then hits (unless killed or the PC changed).
- Miss penalty with zero-wait memory (mem_valid_i tied high): 1 + LINE_WORDS + 1 stall cycles = 6 at defaults. Each memory wait cycle adds one.
- mem_valid_i while mem_req_o=0 is ignored.
- flush_i:
  - In LOOKUP: clears all valid bits at the clock edge. A miss is not started that cycle; stall_o follows the pre-flush hit.
  - In REFILL or DONE: clears all valid bits and sets kill. The current refill still runs to completion (a memory beat cannot be cancelled), but its line is not validated. kill clears on return to LOOKUP.
- If pc_i changes during REFILL (e.g. redirect), the refill of the latched line still completes. Lookup then uses the new pc_i.
- Wrap: miss_count_o wraps from 0xFFFFFFFF to 0.
- rst_n asserted mid-refill: immediate return to LOOKUP with all valid=0 and mem_req_o=0. Any in-flight memory beat is abandoned; backing memory must tolerate this.

Decomposition:
- Package instr_cache_pkg holds:
  - state enum {LOOKUP, REFILL, DONE}.
  - Helper functions for OFF_W, IDX_W and TAG_W derived from the parameters.
- One natural sub-module: icache_line_store (valid/tag/data arrays, combinational read port, word write port, line-validate and invalidate-all). The FSM and counter stay in instr_cache.

Test Plan:
- Cold miss after reset, pc_i=0x00000010, mem_valid_i=1, memory word at address A = A+0x100:
  - stall_o high for 6 cycles, beats at 0x10, 0x14, 0x18, 0x1C.
  - Then instr_o=0x110 with stall_o=0; miss_count_o=1.
- Sequential pc_i 0x14, 0x18, 0x1C after that fill:
  - Hits, stall_o=0, instr_o=0x114, 0x118, 0x11C, no mem_req_o.
- Conflict:
  - pc_i=0x00000410 (same index, different tag) misses and refills; instr_o=0x510.
  - Then pc_i=0x10 misses again; miss_count_o=3.
- Wait states: mem_valid_i low for 2 cycles before each beat:
  - mem_addr_o held stable per beat; stall 14 cycles; correct data.
- flush_i pulsed during beat 2 of a refill:
  - Refill finishes all 4 beats, line stays invalid.
  - Re-lookup misses and refills again.
- rst_n low mid-refill, then released with req_i=0:
  - mem_req_o=0, stall_o=0, miss_count_o=0.
  - Prior lines miss on next access.

Source files
------------

// File: rtl/instr_cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package instr_cache_pkg;

  typedef enum logic [1:0] {
    LOOKUP = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Word-offset width within a line.
  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  // Set-index width.
  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  // Tag width: whatever address bits remain above byte, offset and index fields.
  function automatic int tag_w(input int addr_width, input int num_sets, input int line_words);
    return addr_width - 2 - $clog2(line_words) - $clog2(num_sets);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Flop-based line storage: valid/tag/data arrays with a combinational read port,
// one-word write port, line validate, single-line invalidate and invalidate-all.
module icache_line_store
  import instr_cache_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  NUM_SETS   = 64,
  parameter int  LINE_WORDS = 4,
  parameter int  TAG_W      = 22,
  localparam int IDX_W      = idx_w(NUM_SETS),
  localparam int OFF_W      = off_w(LINE_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // read port
  input  logic [IDX_W-1:0]      rd_idx,
  input  logic [OFF_W-1:0]      rd_off,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  // refill port (word write and line validate share the refill index)
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [OFF_W-1:0]      wr_off,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  val_en,
  input  logic [TAG_W-1:0]      val_tag,
  // invalidation
  input  logic                  inv_one,
  input  logic [IDX_W-1:0]      inv_idx,
  input  logic                  inv_all
);

  logic [NUM_SETS-1:0]   valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_SETS];
  logic [DATA_WIDTH-1:0] data_q [NUM_SETS][LINE_WORDS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_off];

  // Valid bits: invalidate-all wins over any same-cycle validate.
  // NOTE: state uses non-blocking (<=) so every flop samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (inv_all) begin
      valid_q <= '0;
    end else begin
      if (inv_one) valid_q[inv_idx] <= 1'b0;
      if (val_en)  valid_q[wr_idx]  <= 1'b1;
    end
  end

  // Tag captured when the refilled line is validated.
  // NOTE: tag and data arrays are deliberately not reset; the valid bits alone make stale contents harmless.
  always_ff @(posedge clk) begin
    if (val_en) tag_q[wr_idx] <= val_tag;
  end

  // Refill beats land directly in the data array.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_idx][wr_off] <= wr_data;
  end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, stall on miss,
// whole-line refill over a per-word req/valid handshake.
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SETS   = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [31:0]           miss_count_o
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(NUM_SETS);
  localparam int TAG_W = tag_w(ADDR_WIDTH, NUM_SETS, LINE_WORDS);

  state_t            state_q, state_d;
  logic [OFF_W-1:0]  beat_q;
  logic              kill_q;
  logic [IDX_W-1:0]  fill_idx_q;
  logic [TAG_W-1:0]  fill_tag_q;

  logic [OFF_W-1:0]  pc_off;
  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic              hit;
  logic              miss_start;
  logic              beat_accept;
  logic              last_beat;
  logic              unused_byte_bits;

  assign pc_off = pc_i[2+OFF_W-1:2];
  assign pc_idx = pc_i[2+OFF_W+IDX_W-1:2+OFF_W];
  assign pc_tag = pc_i[ADDR_WIDTH-1:2+OFF_W+IDX_W];
  // Instruction fetches are word aligned; the byte bits carry no information.
  assign unused_byte_bits = ^pc_i[1:0];

  assign hit         = rd_valid && (rd_tag == pc_tag);
  // A flush in the same cycle takes priority: nothing is refilled into a cache being wiped.
  assign miss_start  = (state_q == LOOKUP) && req_i && !hit && !flush_i;
  assign beat_accept = (state_q == REFILL) && mem_req_o && mem_valid_i;
  assign last_beat   = beat_accept && (beat_q == OFF_W'(LINE_WORDS - 1));

  icache_line_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_SETS   (NUM_SETS),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (pc_idx),
    .rd_off   (pc_off),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (instr_o),
    .wr_en    (beat_accept),
    .wr_idx   (fill_idx_q),
    .wr_off   (beat_q),
    .wr_data  (mem_rdata_i),
    .val_en   (last_beat && !kill_q),
    .val_tag  (fill_tag_q),
    .inv_one  (miss_start),
    .inv_idx  (pc_idx),
    .inv_all  (flush_i)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOOKUP;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOOKUP:  if (miss_start) state_d = REFILL;
      REFILL:  if (last_beat)  state_d = DONE;
      DONE:    state_d = LOOKUP;
      default: state_d = LOOKUP;
    endcase
  end

  // Fetch-side stall: only a missing request stalls in LOOKUP; refill and the settle cycle always stall.
  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      LOOKUP:       stall_o = req_i && !hit;
      REFILL, DONE: stall_o = 1'b1;
      default:      stall_o = 1'b0;
    endcase
  end

  // Refill sequencing: latch the line on a miss, then walk the beat address/counter on each accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      beat_q       <= '0;
      miss_count_o <= '0;
      fill_idx_q   <= '0;
      fill_tag_q   <= '0;
    end else if (miss_start) begin
      mem_req_o    <= 1'b1;
      mem_addr_o   <= {pc_i[ADDR_WIDTH-1:2+OFF_W], {(2+OFF_W){1'b0}}};
      beat_q       <= '0;
      miss_count_o <= miss_count_o + 32'd1;
      fill_idx_q   <= pc_idx;
      fill_tag_q   <= pc_tag;
    end else if (beat_accept) begin
      beat_q <= beat_q + OFF_W'(1);
      if (last_beat) begin
        mem_req_o <= 1'b0;
      end else begin
        mem_addr_o <= mem_addr_o + ADDR_WIDTH'(4);
      end
    end
  end

  // Kill: a flush during an in-flight refill lets the beats finish but blocks validation of the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_q <= 1'b0;
    end else if (state_q == DONE) begin
      kill_q <= 1'b0;
    end else if ((state_q == REFILL) && flush_i) begin
      kill_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed scenarios plus randomized fetches
// against an abstract cache/memory model, checked by a scoreboard monitor.
module tb_instr_cache;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NS = 64;
  localparam int LW = 4;
  localparam int LINE_BYTES = 4 * LW;
  localparam int SPAN_BYTES = LINE_BYTES * NS;

  logic          clk;
  logic          rst_n;
  logic          req_i;
  logic [AW-1:0] pc_i;
  logic          flush_i;
  logic [DW-1:0] instr_o;
  logic          stall_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_valid_i;
  logic [DW-1:0] mem_rdata_i;
  logic [31:0]   miss_count_o;

  instr_cache #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_SETS   (NS),
    .LINE_WORDS (LW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .instr_o      (instr_o),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_valid_i  (mem_valid_i),
    .mem_rdata_i  (mem_rdata_i),
    .miss_count_o (miss_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          miss;
    int          exp_stall;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] beat_log[$];
  int          addr_unstable = 0;
  int          wait_n = 0;
  bit          wait_rand = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Backing memory content: word at address A holds A + 0x100.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  bit          m_valid [NS];
  logic [31:0] m_tag   [NS];
  int unsigned m_misses = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / LINE_BYTES) % NS);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / SPAN_BYTES;
  endfunction

  function automatic bit is_miss(input logic [31:0] pc);
    return !(m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc)));
  endfunction

  task automatic clear_model();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  function automatic int pick_wait();
    return wait_rand ? int'($urandom_range(0, 2)) : wait_n;
  endfunction

  // ---------------- backing memory responder ----------------
  logic [31:0] held_addr;
  bit          holding;
  int          wait_left;

  initial begin
    mem_valid_i = 1'b0;
    mem_rdata_i = '0;
    holding     = 1'b0;
    wait_left   = 0;
    held_addr   = '0;
    forever begin
      @(negedge clk);
      if (mem_req_o) begin
        if (!holding) begin
          holding   = 1'b1;
          held_addr = mem_addr_o;
        end else if (mem_addr_o !== held_addr) begin
          addr_unstable++;
        end
        if (wait_left == 0) begin
          mem_valid_i = 1'b1;
          mem_rdata_i = mem_word(mem_addr_o);
          beat_log.push_back(mem_addr_o);
          holding     = 1'b0;
          wait_left   = pick_wait();
        end else begin
          mem_valid_i = 1'b0;
          mem_rdata_i = $urandom;
          wait_left--;
        end
      end else begin
        // Idle: random valid/data must be ignored by the cache.
        holding     = 1'b0;
        wait_left   = pick_wait();
        mem_valid_i = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  int   mon_run = 0;
  exp_t mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || !req_i) begin
        mon_run = 0;
      end else if (stall_o) begin
        mon_run++;
      end else begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_fetch: pc 0x%08h accepted with nothing expected", pc_i);
        end else begin
          mon_e = sb.pop_front();
          check("instr", instr_o, mon_e.instr);
          check("miss_seen", 32'(mon_run > 0), 32'(mon_e.miss));
          if (mon_e.exp_stall >= 0) check("stall_cycles", mon_run, mon_e.exp_stall);
        end
        mon_run = 0;
      end
    end
  end

  // ---------------- driver ----------------
  // Fetch pc until accepted. flush_at: -1 none, 0 with the first request cycle,
  // k>0 on the k-th stall cycle (inside the refill). exp_stall -1 = unchecked.
  task automatic fetch(input logic [31:0] pc, input int flush_at, input int exp_stall);
    exp_t e;
    bit   miss;
    bit   acc;
    int   cyc;
    int   ix;
    ix   = idx_of(pc);
    miss = is_miss(pc);
    if (flush_at == 0) clear_model();
    if (miss) begin
      m_misses++;
      if (flush_at > 0) begin
        // Killed line stays invalid, so the re-lookup misses and refills again.
        clear_model();
        m_misses++;
      end
      m_valid[ix] = 1'b1;
      m_tag[ix]   = tag_of(pc);
    end
    e.pc        = pc;
    e.instr     = mem_word({pc[31:2], 2'b00});
    e.miss      = miss;
    e.exp_stall = exp_stall;
    sb.push_back(e);

    req_i   = 1'b1;
    pc_i    = pc;
    flush_i = (flush_at == 0);
    cyc     = 0;
    acc     = 1'b0;
    while (!acc && cyc < 400) begin
      @(negedge clk);
      acc = !stall_o;
      if (!acc) cyc++;
      @(posedge clk);
      #1;
      flush_i = !acc && (cyc == flush_at);
    end
    flush_i = 1'b0;
    check("fetch_accepted", 32'(acc), 32'd1);
    check("miss_count", miss_count_o, m_misses);
  endtask

  task automatic idle(input int n);
    req_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Global time bound.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [31:0] rpc;
  int          r;

  initial begin
    rst_n   = 1'b0;
    req_i   = 1'b0;
    pc_i    = '0;
    flush_i = 1'b0;
    clear_model();

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_miss_count", miss_count_o, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Cold miss, zero-wait memory.
    wait_n = 0; wait_rand = 0;
    beat_log.delete();
    fetch(32'h10, -1, 6);
    check("cold_beat_count", beat_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < beat_log.size(); i++)
      check("cold_beat_addr", beat_log[i], 32'h10 + 32'(4 * i));

    // Sequential hits in the same line: no memory traffic.
    fetch(32'h14, -1, 0);
    fetch(32'h18, -1, 0);
    fetch(32'h1C, -1, 0);
    check("hit_no_mem", beat_log.size(), 32'd4);

    // Conflict on the same index with a different tag, then back.
    fetch(32'h410, -1, 6);
    fetch(32'h10, -1, 6);
    check("conflict_misses", miss_count_o, 32'd3);

    // Two wait cycles before each beat.
    wait_n = 2;
    beat_log.delete();
    addr_unstable = 0;
    fetch(32'h24, -1, 14);
    check("wait_beat_count", beat_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < beat_log.size(); i++)
      check("wait_beat_addr", beat_log[i], 32'h20 + 32'(4 * i));
    check("wait_addr_stable", addr_unstable, 32'd0);
    wait_n = 0;

    // Flush during beat 2 of a refill: line not validated, re-lookup refills again.
    beat_log.delete();
    fetch(32'h30, 3, 12);
    check("flush_refill_beats", beat_log.size(), 32'd8);
    fetch(32'h34, -1, 0);

    // Flush in LOOKUP on a hit: served from the pre-flush hit, then everything misses.
    fetch(32'h38, 0, 0);
    fetch(32'h38, -1, 6);
    fetch(32'h410, -1, 6);
    idle(3);

    // Randomized fetches with random wait states and occasional flushes.
    wait_rand = 1;
    for (int n = 0; n < 300; n++) begin
      rpc = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
      r   = int'($urandom_range(0, 19));
      if (r == 0)                     fetch(rpc, 0, -1);
      else if (r == 1 && is_miss(rpc)) fetch(rpc, 2, -1);
      else if (r == 2)                begin idle(int'($urandom_range(1, 3))); fetch(rpc, -1, -1); end
      else                            fetch(rpc, -1, -1);
    end
    wait_rand = 0;
    wait_n    = 0;
    idle(2);

    // Reset in the middle of a refill.
    req_i = 1'b1;
    pc_i  = 32'h0001_2340;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_mem_req", 32'(mem_req_o), 32'd1);
    rst_n = 1'b0;
    req_i = 1'b0;
    #1;
    check("midreset_mem_req", 32'(mem_req_o), 32'd0);
    check("midreset_stall", 32'(stall_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_model();
    m_misses = 0;
    @(posedge clk);
    #1;
    check("postreset_mem_req", 32'(mem_req_o), 32'd0);
    check("postreset_stall", 32'(stall_o), 32'd0);
    check("postreset_miss_count", miss_count_o, 32'd0);
    fetch(32'h10, -1, 6);
    fetch(32'h410, -1, 6);
    idle(3);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
